// File: rtl/nn_io_pkg.sv
// Shared definitions for the nn_io sequencer: FSM state encoding, default sample width
// and address-width sizing helper.
package nn_io_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } io_state_t;

  // Never returns zero, so a depth of 1 still gets a usable 1-bit address.
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/nn_io_inbuf.sv
// Input sample buffer: posedge write port from the host side and a negedge registered
// read port, so the core sees read data half a cycle after presenting the address.
module nn_io_inbuf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/nn_io_sequencer.sv
// Host-side I/O wrapper for the network core: fill input buffer, run core via req/ack,
// snapshot and stream outputs. Define NN_IO_PINGPONG_EN for a double-buffered input.
module nn_io_sequencer
  import nn_io_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_IN   = 8,
  parameter int N_OUT  = 8,
  parameter int AW_IN  = addr_w(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                    net_req,
  input  logic                    net_ack,
  input  logic [AW_IN-1:0]        net_in_addr,
  output logic [DATA_W-1:0]       net_in_data,
  input  logic [N_OUT*DATA_W-1:0] net_out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err_ovf
);

  localparam int AW_OUT = addr_w(N_OUT);
`ifdef NN_IO_PINGPONG_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  io_state_t                    state;
  logic [AW_IN-1:0]             wr_cnt;
  logic [AW_OUT-1:0]            rd_cnt;
  logic [AW_OUT-1:0]            rd_next;
  logic                         req_armed;
  logic                         fill_bank;
  logic                         accept;
  logic                         wr_wrap;
  logic                         rd_last;
  logic [N_OUT-1:0][DATA_W-1:0] out_buf;
  logic [DATA_W-1:0]            bank_rd [NUM_BANKS];

  assign accept  = in_valid & in_ready;
  assign wr_wrap = (wr_cnt == AW_IN'(N_IN - 1));
  assign rd_next = rd_cnt + 1'b1;
  assign rd_last = (rd_cnt == AW_OUT'(N_OUT - 1));

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    nn_io_inbuf #(
      .DATA_W (DATA_W),
      .DEPTH  (N_IN),
      .AW     (AW_IN)
    ) u_inbuf (
      .clk     (clk),
      .rst     (rst),
      .we      (accept && (fill_bank == 1'(b))),
      .wr_addr (wr_cnt),
      .wr_data (in_data),
      .rd_addr (net_in_addr),
      .rd_data (bank_rd[b])
    );
  end

`ifdef NN_IO_PINGPONG_EN
  // The core always reads the bank the host is not currently filling.
  logic fill_full;
  logic fill_done;
  assign fill_done   = fill_full | (accept & wr_wrap);
  assign net_in_data = bank_rd[~fill_bank];
`else
  assign net_in_data = bank_rd[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      req_armed <= 1'b0;
      fill_bank <= 1'b0;
      in_ready  <= 1'b0;
      net_req   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      err_ovf   <= 1'b0;
`ifdef NN_IO_PINGPONG_EN
      fill_full <= 1'b0;
`endif
    end else begin
      if (accept) begin
        wr_cnt <= wr_wrap ? '0 : wr_cnt + 1'b1;
      end

      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept && wr_wrap) begin
            state     <= REQ;
            net_req   <= 1'b1;
            req_armed <= 1'b0;
            busy      <= 1'b1;
`ifdef NN_IO_PINGPONG_EN
            fill_bank <= ~fill_bank;
`else
            in_ready  <= 1'b0;
`endif
          end
        end

        // req_armed masks a stale ack still high from the previous round.
        REQ: begin
          req_armed <= 1'b1;
          if (req_armed && net_ack) begin
            state     <= DRAIN;
            net_req   <= 1'b0;
            out_buf   <= net_out_data;
            rd_cnt    <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= net_out_data[DATA_W-1:0];
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (rd_last) begin
              rd_cnt    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
`ifdef NN_IO_PINGPONG_EN
              if (fill_done) begin
                state     <= REQ;
                net_req   <= 1'b1;
                req_armed <= 1'b0;
                fill_bank <= ~fill_bank;
              end else begin
                state <= FILL;
                busy  <= 1'b0;
              end
`else
              state    <= FILL;
              busy     <= 1'b0;
              in_ready <= 1'b1;
`endif
            end else begin
              rd_cnt   <= rd_next;
              out_data <= out_buf[rd_next];
              out_last <= (rd_next == AW_OUT'(N_OUT - 1));
            end
          end
        end

        default: state <= FILL;
      endcase

`ifdef NN_IO_PINGPONG_EN
      // Outside FILL the host keeps filling the spare bank until it is complete.
      if (state != FILL) begin
        if (state == DRAIN && out_ready && rd_last && fill_done) begin
          fill_full <= 1'b0;
          in_ready  <= 1'b1;
        end else if (accept && wr_wrap) begin
          fill_full <= 1'b1;
          in_ready  <= 1'b0;
        end
      end
`else
      if (state == REQ && in_valid) begin
        err_ovf <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_nn_io_sequencer.sv
// Randomized self-checking bench for nn_io_sequencer; the bench acts as both the host
// and the network core, predicting results from accepted-word and snapshot queues.
module tb_nn_io_sequencer;

  localparam int DATA_W = 8;
  localparam int N_IN   = 8;
  localparam int N_OUT  = 8;
  localparam int AW_IN  = $clog2(N_IN);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data = '0;
  logic                    net_req;
  logic                    net_ack = 1'b0;
  logic [AW_IN-1:0]        net_in_addr = '0;
  logic [DATA_W-1:0]       net_in_data;
  logic [N_OUT*DATA_W-1:0] net_out_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic                    busy;
  logic                    err_ovf;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic              last_q[$];
  logic [DATA_W-1:0] rd_arr[N_IN];
  int                handshakes;
  int                stall_changes;

  always #5 clk = ~clk;

  nn_io_sequencer #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .N_OUT  (N_OUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .net_req      (net_req),
    .net_ack      (net_ack),
    .net_in_addr  (net_in_addr),
    .net_in_data  (net_in_data),
    .net_out_data (net_out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .err_ovf      (err_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host side: offer n words, recording exactly those the sequencer accepted.
  task automatic send_words(input int n, input bit rnd, input int base, input int gap_pct,
                            output int cycles);
    int sent;
    bit acc;
    sent   = 0;
    cycles = 0;
    while (sent < n && cycles < 500) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = rnd ? DATA_W'($urandom) : DATA_W'(base + sent);
      end
      acc = in_valid && in_ready;
      tick();
      cycles++;
      if (acc) begin
        in_q.push_back(in_data);
        sent++;
      end
    end
    in_valid = 1'b0;
    if (sent < n) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL send_timeout: accepted %0d words, required %0d", sent, n);
    end
  endtask

  // Core side: read every input address (optionally starting at a random rotation).
  task automatic read_inbuf(input bit rotate);
    int off;
    int a;
    off = rotate ? $urandom_range(N_IN - 1) : 0;
    for (int k = 0; k < N_IN; k++) begin
      a = (k + off) % N_IN;
      net_in_addr = AW_IN'(a);
      @(negedge clk);
      #1;
      rd_arr[a] = net_in_data;
      tick();
    end
  endtask

  task automatic load_out_words(input bit fixed);
    logic [DATA_W-1:0] w;
    exp_q.delete();
    for (int k = 0; k < N_OUT; k++) begin
      w = fixed ? DATA_W'(-(k + 1)) : DATA_W'($urandom);
      net_out_data[k*DATA_W +: DATA_W] = w;
      exp_q.push_back(w);
    end
  endtask

  task automatic scramble_out();
    for (int k = 0; k < N_OUT; k++) begin
      net_out_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
  endtask

  task automatic ack_core(input bit fixed);
    load_out_words(fixed);
    net_ack = 1'b1;
    tick();
    net_ack = 1'b0;
    scramble_out();
  endtask

  // Downstream side: mode 0 always ready, 1 repeats 1,0,0,1, 2 random.
  task automatic drain(input int mode);
    bit pat[4];
    bit stalled;
    bit acc;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;
    int cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    got_q.delete();
    last_q.delete();
    handshakes    = 0;
    stall_changes = 0;
    stalled       = 1'b0;
    prev_data     = '0;
    prev_last     = 1'b0;
    cyc           = 0;
    while (handshakes < N_OUT && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(1));
      if (stalled && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        stall_changes++;
      acc = (out_valid === 1'b1) && out_ready;
      if (acc) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        handshakes++;
      end
      stalled   = (out_valid === 1'b1) && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready); end
    compared++; if (net_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_net_req: got %b required 0", net_req); end
    compared++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_flags: got valid=%b last=%b required 0/0", out_valid, out_last); end
    compared++; if (busy !== 1'b0 || err_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_status: got busy=%b err_ovf=%b required 0/0", busy, err_ovf); end
    compared++; if (out_data !== '0 || net_in_data !== '0) begin mismatched++; $display("[TB] FAIL reset_data: got out=%0h net_in=%0h required 0/0", out_data, net_in_data); end
    rst = 1'b0;
    tick();
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_release_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    int cyc;
    send_words(N_IN - 1, 1'b0, 1, 0, cyc);
    compared++; if (net_req !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_early_req: got req=%b busy=%b required 0/0", net_req, busy); end
    send_words(1, 1'b0, N_IN, 0, cyc);
    compared++; if (net_req !== 1'b1 || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_req_rise: got req=%b busy=%b required 1/1", net_req, busy); end
`ifdef NN_IO_PINGPONG_EN
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_in_ready_req: got %b required 1", in_ready); end
`else
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_in_ready_req: got %b required 0", in_ready); end
`endif
    read_inbuf(1'b0);
    for (int a = 0; a < N_IN; a++) begin
      compared++;
      if (rd_arr[a] !== DATA_W'(a + 1)) begin mismatched++; $display("[TB] FAIL basic_read[%0d]: got %0h required %0h", a, rd_arr[a], a + 1); end
    end
    in_q.delete();
    compared++; if (net_req !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_req_hold: got %b required 1", net_req); end
    ack_core(1'b1);
    compared++; if (net_req !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_ack: got req=%b valid=%b busy=%b required 0/1/1", net_req, out_valid, busy); end
    compared++; if (out_data !== 8'hFF || out_last !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_first_word: got %0h last=%b required ff/0", out_data, out_last); end
    drain(0);
    compared++; if (handshakes !== N_OUT) begin mismatched++; $display("[TB] FAIL basic_handshakes: got %0d required %0d", handshakes, N_OUT); end
    for (int k = 0; k < got_q.size(); k++) begin
      compared++;
      if (got_q[k] !== exp_q[k] || last_q[k] !== (k == N_OUT - 1)) begin mismatched++; $display("[TB] FAIL basic_out[%0d]: got %0h last=%b required %0h last=%b", k, got_q[k], last_q[k], exp_q[k], k == N_OUT - 1); end
    end
    compared++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_back_to_fill: got busy=%b valid=%b in_ready=%b required 0/0/1", busy, out_valid, in_ready); end
    compared++; if (err_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_err_ovf: got %b required 0", err_ovf); end
  endtask

  task automatic test_backpressure();
    int cyc;
    send_words(N_IN, 1'b1, 0, 25, cyc);
    read_inbuf(1'b1);
    for (int a = 0; a < N_IN; a++) begin
      compared++;
      if (rd_arr[a] !== in_q[a]) begin mismatched++; $display("[TB] FAIL bp_read[%0d]: got %0h required %0h", a, rd_arr[a], in_q[a]); end
    end
    in_q.delete();
    ack_core(1'b0);
    drain(1);
    compared++; if (handshakes !== N_OUT) begin mismatched++; $display("[TB] FAIL bp_handshakes: got %0d required %0d", handshakes, N_OUT); end
    compared++; if (stall_changes !== 0) begin mismatched++; $display("[TB] FAIL bp_stall_stable: got %0d changes required 0", stall_changes); end
    for (int k = 0; k < got_q.size(); k++) begin
      compared++;
      if (got_q[k] !== exp_q[k] || last_q[k] !== (k == N_OUT - 1)) begin mismatched++; $display("[TB] FAIL bp_out[%0d]: got %0h last=%b required %0h last=%b", k, got_q[k], last_q[k], exp_q[k], k == N_OUT - 1); end
    end
  endtask

  task automatic test_stale_ack();
    int cyc;
    net_ack = 1'b1;
    send_words(N_IN, 1'b1, 0, 0, cyc);
    in_q.delete();
    load_out_words(1'b0);
    tick();
    compared++; if (net_req !== 1'b1 || out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL stale_ack_ignored: got req=%b valid=%b required 1/0", net_req, out_valid); end
    load_out_words(1'b0);
    tick();
    scramble_out();
    compared++; if (net_req !== 1'b0 || out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stale_ack_complete: got req=%b valid=%b required 0/1", net_req, out_valid); end
    drain(2);
    compared++; if (handshakes !== N_OUT) begin mismatched++; $display("[TB] FAIL stale_handshakes: got %0d required %0d", handshakes, N_OUT); end
    for (int k = 0; k < got_q.size(); k++) begin
      compared++;
      if (got_q[k] !== exp_q[k]) begin mismatched++; $display("[TB] FAIL stale_out[%0d]: got %0h required %0h", k, got_q[k], exp_q[k]); end
    end
    tick();
    compared++; if (net_req !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL stale_fill_ignores_ack: got req=%b busy=%b required 0/0", net_req, busy); end
    net_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    send_words(5, 1'b1, 0, 20, cyc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_q.delete();
    compared++; if (in_ready !== 1'b0 || net_req !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_outputs: got rdy=%b req=%b busy=%b valid=%b required 0/0/0/0", in_ready, net_req, busy, out_valid); end
    send_words(3, 1'b1, 0, 0, cyc);
    compared++; if (net_req !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_discard: got req=%b required 0", net_req); end
    send_words(N_IN - 3, 1'b1, 0, 0, cyc);
    compared++; if (net_req !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_new_round: got req=%b required 1", net_req); end
    read_inbuf(1'b1);
    for (int a = 0; a < N_IN; a++) begin
      compared++;
      if (rd_arr[a] !== in_q[a]) begin mismatched++; $display("[TB] FAIL midrst_read[%0d]: got %0h required %0h", a, rd_arr[a], in_q[a]); end
    end
    in_q.delete();
    ack_core(1'b0);
    drain(2);
    for (int k = 0; k < got_q.size(); k++) begin
      compared++;
      if (got_q[k] !== exp_q[k]) begin mismatched++; $display("[TB] FAIL midrst_out[%0d]: got %0h required %0h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int r = 0; r < 3; r++) begin
      send_words(N_IN, 1'b1, 0, 30, cyc);
      read_inbuf(1'b1);
      for (int a = 0; a < N_IN; a++) begin
        compared++;
        if (rd_arr[a] !== in_q[a]) begin mismatched++; $display("[TB] FAIL b2b_read[%0d][%0d]: got %0h required %0h", r, a, rd_arr[a], in_q[a]); end
      end
      in_q.delete();
      ack_core(1'b0);
      drain(2);
      compared++; if (handshakes !== N_OUT) begin mismatched++; $display("[TB] FAIL b2b_handshakes[%0d]: got %0d required %0d", r, handshakes, N_OUT); end
      for (int k = 0; k < got_q.size(); k++) begin
        compared++;
        if (got_q[k] !== exp_q[k] || last_q[k] !== (k == N_OUT - 1)) begin mismatched++; $display("[TB] FAIL b2b_out[%0d][%0d]: got %0h last=%b required %0h", r, k, got_q[k], last_q[k], exp_q[k]); end
      end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready_next[%0d]: got %b required 1", r, in_ready); end
    end
  endtask

`ifdef NN_IO_PINGPONG_EN
  task automatic test_pingpong();
    int cyc;
    send_words(2 * N_IN, 1'b0, 1, 0, cyc);
    compared++; if (cyc !== 2 * N_IN) begin mismatched++; $display("[TB] FAIL pp_stream_cycles: got %0d required %0d", cyc, 2 * N_IN); end
    compared++; if (net_req !== 1'b1 || in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL pp_full: got req=%b rdy=%b required 1/0", net_req, in_ready); end
    for (int r = 0; r < 2; r++) begin
      read_inbuf(1'b1);
      for (int a = 0; a < N_IN; a++) begin
        compared++;
        if (rd_arr[a] !== in_q[a]) begin mismatched++; $display("[TB] FAIL pp_read[%0d][%0d]: got %0h required %0h", r, a, rd_arr[a], in_q[a]); end
      end
      repeat (N_IN) void'(in_q.pop_front());
      ack_core(1'b0);
      drain(0);
      for (int k = 0; k < got_q.size(); k++) begin
        compared++;
        if (got_q[k] !== exp_q[k]) begin mismatched++; $display("[TB] FAIL pp_out[%0d][%0d]: got %0h required %0h", r, k, got_q[k], exp_q[k]); end
      end
      if (r == 0) begin
        compared++; if (net_req !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL pp_direct_req: got req=%b busy=%b rdy=%b required 1/1/1", net_req, busy, in_ready); end
      end
    end
    compared++; if (net_req !== 1'b0 || busy !== 1'b0 || err_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL pp_end: got req=%b busy=%b ovf=%b required 0/0/0", net_req, busy, err_ovf); end
  endtask
`else
  task automatic test_overflow();
    int cyc;
    send_words(N_IN, 1'b1, 0, 20, cyc);
    in_valid = 1'b1;
    in_data  = DATA_W'($urandom);
    tick();
    in_valid = 1'b0;
    compared++; if (err_ovf !== 1'b1 || in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_set: got ovf=%b rdy=%b required 1/0", err_ovf, in_ready); end
    read_inbuf(1'b1);
    for (int a = 0; a < N_IN; a++) begin
      compared++;
      if (rd_arr[a] !== in_q[a]) begin mismatched++; $display("[TB] FAIL ovf_read[%0d]: got %0h required %0h", a, rd_arr[a], in_q[a]); end
    end
    in_q.delete();
    ack_core(1'b0);
    drain(2);
    send_words(N_IN, 1'b1, 0, 0, cyc);
    compared++; if (err_ovf !== 1'b1 || net_req !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got ovf=%b req=%b required 1/1", err_ovf, net_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_q.delete();
    compared++; if (err_ovf !== 1'b0 || net_req !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_rst_clear: got ovf=%b req=%b busy=%b required 0/0/0", err_ovf, net_req, busy); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stale_ack();
    test_reset_mid();
    test_back_to_back();
`ifdef NN_IO_PINGPONG_EN
    test_pingpong();
`else
    test_overflow();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
